// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU; one operation in flight at a time.
// Tie-break is fixed priority (port 0) by default; define ALU_ARBITER_RR_EN for round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_res,
    output logic              rsp0_zero,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_res,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero
);

    // state | meaning
    // IDLE  | waiting for a request; grants and latches operands in the same cycle
    // EXEC  | operands on the shared ALU; result captured at end of cycle
    // RESP  | result presented to the granted port until it is consumed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;
    logic              sel;

`ifdef ALU_ARBITER_RR_EN
    logic              prio_q, prio_d;

    // prio_q names the port that wins the next tie
    always_comb begin
        if (req0_valid && req1_valid) sel = prio_q;
        else                          sel = !req0_valid;
    end
`else
    always_comb sel = !req0_valid;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        a_d        = a_q;
        b_d        = b_q;
        ctrl_d     = ctrl_q;
        res_d      = res_q;
        zero_d     = zero_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
`ifdef ALU_ARBITER_RR_EN
        prio_d     = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if ((req0_valid || req1_valid) && !rst) begin
                    req0_ready = !sel;
                    req1_ready = sel;
                    grant_d    = sel;
                    a_d        = sel ? req1_a    : req0_a;
                    b_d        = sel ? req1_b    : req0_b;
                    ctrl_d     = sel ? req1_ctrl : req0_ctrl;
                    state_d    = EXEC;
`ifdef ALU_ARBITER_RR_EN
                    prio_d     = !sel;
`endif
                end
            end
            EXEC: begin
                res_d   = alu_res;
                zero_d  = alu_zero;
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = !grant_q && !rst;
                rsp1_valid = grant_q && !rst;
                if (grant_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
`ifdef ALU_ARBITER_RR_EN
            prio_q  <= prio_d;
`endif
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_ctrl  = ctrl_q;
    assign rsp0_res  = res_q;
    assign rsp1_res  = res_q;
    assign rsp0_zero = zero_q;
    assign rsp1_zero = zero_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the operand/result width; only 32 is supported.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 reqN_valid  input  1  (N=0,1) SHALL flag that requester N has an operation pending.
REQ-005 reqN_ready  output  1  SHALL flag that requester N's operation is accepted this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  SHALL carry operands A and B.
REQ-007 reqN_ctrl  input  4  SHALL carry the ALU op code (add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111).
REQ-008 rspN_valid  output  1  SHALL flag that requester N's result is available.
REQ-009 rspN_ready  input  1  SHALL flag that requester N consumes the result.
REQ-010 rspN_res  output  32  SHALL carry the result; rspN_zero  output  1  SHALL carry the zero flag.
REQ-011 alu_a, alu_b  output  32; alu_ctrl  output  4  SHALL drive the shared combinational ALU.
REQ-012 alu_res  input  32; alu_zero  input  1  SHALL return the shared ALU's combinational outputs.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at a time.
REQ-014 IDLE: if any reqN_valid, grant one port, assert its reqN_ready combinationally in the same cycle, latch its a/b/ctrl into operand registers, record grant, go EXEC.
REQ-015 reqN_ready SHALL be asserted only in IDLE, only for the granted port, and only when reqN_valid is high; never for both ports.
REQ-016 alu_a/alu_b/alu_ctrl SHALL always be driven from the operand registers, never from reqN_* directly.
REQ-017 EXEC (exactly one cycle): capture alu_res and alu_zero into result registers, go RESP.
REQ-018 RESP: assert rspG_valid for granted port G only; rspN_res/rspN_zero of both ports SHALL show the result registers; hold until rspG_ready, then go IDLE.
REQ-019 Latency: handshake at cycle T -> rspG_valid high from cycle T+2; with rspG_ready held high, the next acceptance occurs at T+3 (throughput one op per 3 cycles).
REQ-020 rspG_valid, rspG_res, rspG_zero SHALL remain stable while rspG_ready is low.
REQ-021 Operand/ctrl changes on a port while its reqN_ready is low SHALL be ignored; reqN_valid dropping before acceptance SHALL withdraw the request without side effects.
REQ-022 rspN_ready asserted by a non-granted port, or outside RESP, SHALL be ignored.
REQ-023 Undefined ctrl codes SHALL be passed through unchanged; result is whatever the ALU returns.

Reset
REQ-024 On rst high at a clock edge: state IDLE, operand and result registers 0, grant record 0, priority pointer such that port 0 wins the next tie.
REQ-025 During and after reset: reqN_ready=0 while rst high, rspN_valid=0, rspN_res=0, rspN_zero=0 (result register 0 -> zero output 0 until first capture), alu_a=alu_b=0, alu_ctrl=0000.
REQ-026 rst asserted in EXEC or RESP SHALL discard the in-flight operation; no response is issued for it.

Configuration
REQ-027 Macro ALU_ARBITER_RR_EN defined: tie-break SHALL be round-robin -- on simultaneous valids, grant the port not granted last; pointer updates on every grant.
REQ-028 ALU_ARBITER_RR_EN undefined: tie-break SHALL be fixed priority, port 0 always wins; no pointer register exists.

Verification
REQ-029 Single op: req0 a=5,b=3,ctrl=1000 accepted at T -> rsp0_valid at T+2, rsp0_res=2, rsp0_zero=0, rsp1_valid=0 throughout.
REQ-030 Zero flag: req1 a=7,b=7,ctrl=0100 -> rsp1_res=0, rsp1_zero=1; slt a=0xFFFFFFFF,b=1 -> res=1; sltu same operands -> res=0.
REQ-031 Backpressure: rsp0_ready low 5 cycles after rsp0_valid -> valid/res stable, req0_ready and req1_ready stay 0 until release.
REQ-032 Contention with RR_EN: both ports valid continuously -> grants alternate 0,1,0,1; without RR_EN -> port 0 granted every time, port 1 never.
REQ-033 Reset mid-op: rst high in EXEC of sra a=0x80000000,b=4 -> no rsp valid afterward; all outputs 0; next request served normally with port 0 winning a tie.
